// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 25-opcode datapath
// with imem/dmem handshakes, latched opcode, fault reporting and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int MUL_CYCLES    = 4,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic        br_cond,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  dmem_size,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic [31:0] instr_count,
    output logic        halted,
    output logic [1:0]  fault
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state, state_nxt;
    logic [5:0]  opcode_q;
    logic [3:0]  mul_cnt;
    logic [31:0] to_cnt;
    logic [1:0]  fault_q, fault_nxt;
    logic [3:0]  i_alu;
    logic is_r, is_i, is_ld, is_st, is_lui, is_mul, is_br, is_j, is_jal, is_jr, mul_last, to_hit;
    assign is_r   = opcode_q <= 6'd5;
    assign is_i   = opcode_q inside {[6'd6:6'd10]};
    assign is_ld  = opcode_q inside {[6'd11:6'd13]};
    assign is_lui = opcode_q == 6'd14;
    assign is_mul = opcode_q == 6'd15;
    assign is_st  = opcode_q inside {[6'd16:6'd18]};
    assign is_br  = opcode_q inside {[6'd19:6'd21]};
    assign is_j   = opcode_q == 6'd22;
    assign is_jal = opcode_q == 6'd23;
    assign is_jr  = opcode_q == 6'd24;
    // addi/subi/andi/ori/slti skip nor (3) in the ALU encoding
    assign i_alu    = opcode_q[3:0] - (opcode_q >= 6'd9 ? 4'd5 : 4'd6);
    assign mul_last = mul_cnt == 4'(MUL_CYCLES - 1);
    assign to_hit   = FETCH_TIMEOUT != 0 && to_cnt == 32'(FETCH_TIMEOUT - 1);
    assign fault    = fault_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            opcode_q    <= '0;
            mul_cnt     <= '0;
            to_cnt      <= '0;
            fault_q     <= '0;
            instr_count <= '0;
        end else begin
            state   <= state_nxt;
            fault_q <= fault_nxt;
            if (state == DECODE)
                opcode_q <= opcode;
            mul_cnt <= (state == EXEC && state_nxt == EXEC) ? mul_cnt + 4'd1 : 4'd0;
            to_cnt  <= (state == FETCH && !imem_ack) ? to_cnt + 32'd1 : 32'd0;
            if (retire)
                instr_count <= instr_count + 32'd1;
        end
    end
    always_comb begin
        state_nxt   = state;
        fault_nxt   = fault_q;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        alu_op      = 4'd0;
        alu_src_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_size   = 2'd0;
        reg_we      = 1'b0;
        reg_dst     = 2'd0;
        wb_sel      = 2'd0;
        retire      = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: state_nxt = start ? FETCH : IDLE;
            FETCH: begin
                imem_req  = 1'b1;
                ir_we     = 1'b1;
                pc_we     = imem_ack;
                state_nxt = imem_ack ? DECODE : to_hit ? HALT : FETCH;
                fault_nxt = (!imem_ack && to_hit) ? 2'd2 : fault_q;
            end
            DECODE: begin
                retire    = opcode == 6'd63;
                state_nxt = opcode > 6'd24 ? HALT : EXEC;
                fault_nxt = (opcode > 6'd24 && opcode != 6'd63) ? 2'd1 : fault_q;
            end
            EXEC: begin
                alu_op      = is_r ? opcode_q[3:0] : is_i ? i_alu : is_lui ? 4'd7 : is_mul ? 4'd6 : 4'd0;
                alu_src_imm = is_i | is_ld | is_st | is_lui;
                pc_we       = is_br ? br_cond : (is_j | is_jal | is_jr);
                pc_sel      = is_br ? 2'd1 : is_jr ? 2'd3 : (is_j | is_jal) ? 2'd2 : 2'd0;
                reg_we      = is_jal;
                reg_dst     = is_jal ? 2'd2 : 2'd0;
                wb_sel      = is_jal ? 2'd2 : 2'd0;
                retire      = is_br | is_j | is_jal | is_jr;
                state_nxt   = retire ? FETCH : (is_ld | is_st) ? MEM : (is_mul && !mul_last) ? EXEC : WB;
            end
            MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = is_st;
                dmem_size = opcode_q[1:0] - (is_st ? 2'd0 : 2'd3);
                retire    = is_st & dmem_ack;
                state_nxt = !dmem_ack ? MEM : is_st ? FETCH : WB;
            end
            WB: begin
                reg_we    = 1'b1;
                reg_dst   = (is_r | is_mul) ? 2'd0 : 2'd1;
                wb_sel    = is_ld ? 2'd1 : 2'd0;
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            HALT: halted = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end
endmodule
